// File: rtl/enigma_pkg.sv
// Shared types and the inverse column-permutation table for the decrypt-side column stage.
package enigma_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Indexed [sel][row][out_col] -> stored column feeding that output column.
    localparam logic [0:3][0:3][0:3][1:0] COL_INV = '{
        '{ '{2'd2, 2'd1, 2'd0, 2'd3},
           '{2'd3, 2'd1, 2'd0, 2'd2},
           '{2'd2, 2'd1, 2'd0, 2'd3},
           '{2'd2, 2'd1, 2'd0, 2'd3} },
        '{ '{2'd1, 2'd0, 2'd3, 2'd2},
           '{2'd1, 2'd0, 2'd3, 2'd2},
           '{2'd1, 2'd0, 2'd3, 2'd2},
           '{2'd1, 2'd0, 2'd3, 2'd2} },
        '{ '{2'd0, 2'd3, 2'd2, 2'd1},
           '{2'd0, 2'd3, 2'd2, 2'd1},
           '{2'd0, 2'd3, 2'd2, 2'd1},
           '{2'd0, 2'd3, 2'd2, 2'd1} },
        '{ '{2'd2, 2'd3, 2'd0, 2'd1},
           '{2'd2, 2'd3, 2'd0, 2'd1},
           '{2'd2, 2'd3, 2'd0, 2'd1},
           '{2'd2, 2'd3, 2'd0, 2'd1} }
    };

endpackage

// File: rtl/column_inv_map.sv
// Combinational lookup: (sel, row, output column) -> stored source column.
module column_inv_map
    import enigma_pkg::*;
(
    input  logic [1:0] sel,
    input  logic [1:0] row,
    input  logic [1:0] col,
    output logic [1:0] src
);

    assign src = COL_INV[sel][row][col];

endmodule

// File: rtl/column_inv_stream.sv
// Buffers a 16-byte block byte-serially, then drains it through the inverse column permutation.
// Optional block counter output enabled by defining COLINV_BLKCNT_EN.
module column_inv_stream
    import enigma_pkg::*;
#(
    parameter int BW   = 8,
    parameter int NROW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s3,
    input  logic          s4,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_byte,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_byte,
    output logic          out_last,
`ifdef COLINV_BLKCNT_EN
    output logic [15:0]   blk_cnt,
`endif
    output logic          busy
);

    localparam int DEPTH = NROW * 4;

    state_e        state, state_nxt;
    logic [3:0]    wr_cnt, rd_cnt;
    logic [1:0]    sel;
    logic [BW-1:0] mem [DEPTH];
    logic          wr_en, rd_en, first_wr;
    logic [3:0]    wr_idx;
    logic [1:0]    rd_row, rd_col;
    logic [3:0][1:0] src_col;

    assign in_ready  = (state != DRAIN);
    assign out_valid = (state == DRAIN);
    assign busy      = (state != IDLE);
    assign rd_en     = out_valid && out_ready;
    assign rd_row    = rd_cnt[3:2];
    assign rd_col    = rd_cnt[1:0];

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        first_wr  = 1'b0;
        wr_idx    = wr_cnt;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    wr_en     = 1'b1;
                    first_wr  = 1'b1;
                    wr_idx    = 4'd0;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (wr_cnt == 4'd15) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready && rd_cnt == 4'd15) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_cnt <= 4'd0;
            rd_cnt <= 4'd0;
            sel    <= 2'd0;
        end else begin
            state <= state_nxt;
            if (first_wr) begin
                sel    <= {s3, s4};
                wr_cnt <= 4'd1;
            end else if (wr_en) begin
                wr_cnt <= (wr_cnt == 4'd15) ? 4'd0 : wr_cnt + 4'd1;
            end
            if (wr_en && state == LOAD && wr_cnt == 4'd15) begin
                rd_cnt <= 4'd0;
            end else if (rd_en) begin
                rd_cnt <= (rd_cnt == 4'd15) ? 4'd0 : rd_cnt + 4'd1;
            end
        end
    end

    // Buffer content is don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= in_byte;
    end

    for (genvar j = 0; j < 4; j++) begin : g_map
        column_inv_map u_map (
            .sel (sel),
            .row (rd_row),
            .col (2'(j)),
            .src (src_col[j])
        );
    end

    always_comb begin
        out_byte = '0;
        out_last = 1'b0;
        if (state == DRAIN) begin
            out_byte = mem[{rd_row, src_col[rd_col]}];
            out_last = (rd_cnt == 4'd15);
        end
    end

`ifdef COLINV_BLKCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  blk_cnt <= 16'd0;
        else if (rd_en && out_last)  blk_cnt <= blk_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_column_inv_stream.sv
// Directed bench for column_inv_stream: fixed vectors, stalls, mid-block sel change, reset abort, round trips.
module tb_column_inv_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s3, s4;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_last;
    logic       busy;
`ifdef COLINV_BLKCNT_EN
    logic [15:0] blk_cnt;
`endif

    int checks = 0;
    int errors = 0;

    column_inv_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s3        (s3),
        .s4        (s4),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
`ifdef COLINV_BLKCNT_EN
        .blk_cnt   (blk_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] seq0 [16];
    logic [7:0] seq1 [16];
    logic [7:0] e00  [16];
    logic [7:0] e01  [16];
    logic [7:0] e10  [16];
    logic [7:0] e11  [16];
    logic [1:0] tinv [4][4][4];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Feeds 16 bytes; sel switches to sel_late from byte index `flip_at` onward.
    task automatic push(input logic [7:0] b[16], input logic [1:0] sel,
                        input logic [1:0] sel_late, input int flip_at);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("in_ready_load", int'(in_ready), 1);
            chk("busy_load", int'(busy), (i != 0) ? 1 : 0);
            in_valid = 1'b1;
            in_byte  = b[i];
            {s3, s4} = (i >= flip_at) ? sel_late : sel;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("latency_out_valid", int'(out_valid), 1);
    endtask

    task automatic pull(input logic [7:0] e[16], input bit toggle);
        int  k   = 0;
        int  cyc = 0;
        bit  rdy = 1'b1;
        while (k < 16) begin
            if (cyc > 100) begin
                chk("drain_timeout", k, 16);
                break;
            end
            out_ready = rdy;
            #1;
            chk("drain_out_valid", int'(out_valid), 1);
            chk("drain_in_ready", int'(in_ready), 0);
            chk("drain_out_byte", int'(out_byte), int'(e[k]));
            chk("drain_out_last", int'(out_last), (k == 15) ? 1 : 0);
            if (rdy) k++;
            if (toggle) rdy = !rdy;
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("post_out_valid", int'(out_valid), 0);
        chk("post_in_ready", int'(in_ready), 1);
        chk("post_busy", int'(busy), 0);
    endtask

    initial begin
        logic [7:0] orig [16];
        logic [7:0] fwd  [16];

        e00 = '{8'h02,8'h01,8'h00,8'h03, 8'h07,8'h05,8'h04,8'h06,
                8'h0A,8'h09,8'h08,8'h0B, 8'h0E,8'h0D,8'h0C,8'h0F};
        e01 = '{8'h01,8'h00,8'h03,8'h02, 8'h05,8'h04,8'h07,8'h06,
                8'h09,8'h08,8'h0B,8'h0A, 8'h0D,8'h0C,8'h0F,8'h0E};
        e11 = '{8'h02,8'h03,8'h00,8'h01, 8'h06,8'h07,8'h04,8'h05,
                8'h0A,8'h0B,8'h08,8'h09, 8'h0E,8'h0F,8'h0C,8'h0D};
        e10 = '{8'h10,8'h13,8'h12,8'h11, 8'h14,8'h17,8'h16,8'h15,
                8'h18,8'h1B,8'h1A,8'h19, 8'h1C,8'h1F,8'h1E,8'h1D};
        for (int i = 0; i < 16; i++) begin
            seq0[i] = 8'(i);
            seq1[i] = 8'(8'h10 + i);
        end
        for (int r = 0; r < 4; r++) begin
            tinv[0][r] = (r == 1) ? '{2'd3,2'd1,2'd0,2'd2} : '{2'd2,2'd1,2'd0,2'd3};
            tinv[1][r] = '{2'd1,2'd0,2'd3,2'd2};
            tinv[2][r] = '{2'd0,2'd3,2'd2,2'd1};
            tinv[3][r] = '{2'd2,2'd3,2'd0,2'd1};
        end

        rst_n = 1'b0; in_valid = 1'b0; in_byte = '0; out_ready = 1'b0; {s3, s4} = 2'b00;
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_byte", int'(out_byte), 0);
`ifdef COLINV_BLKCNT_EN
        chk("rst_blk_cnt", int'(blk_cnt), 0);
`endif
        @(negedge clk); rst_n = 1'b1;

        push(seq0, 2'b00, 2'b00, 16); pull(e00, 1'b0);
        push(seq0, 2'b11, 2'b11, 16); pull(e11, 1'b0);
        push(seq0, 2'b01, 2'b01, 16); pull(e01, 1'b1);
        // sel change after byte 3 must be ignored
        push(seq0, 2'b00, 2'b10, 4);  pull(e00, 1'b0);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk); in_valid = 1'b1; in_byte = 8'hA0 + 8'(i); {s3, s4} = 2'b01;
        end
        @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_out_byte", int'(out_byte), 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle_out_valid", int'(out_valid), 0);
        push(seq1, 2'b10, 2'b10, 16); pull(e10, 1'b0);

        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 16; i++) orig[i] = 8'($urandom_range(0, 255));
            for (int r = 0; r < 4; r++)
                for (int j = 0; j < 4; j++)
                    fwd[r*4 + int'(tinv[s][r][j])] = orig[r*4 + j];
            push(fwd, 2'(s), 2'(s), 16);
            pull(orig, s[0]);
        end
`ifdef COLINV_BLKCNT_EN
        chk("blk_cnt_final", int'(blk_cnt), 9);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
